// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the L1 data cache controller.
// Address layout: {tag, index, offset[4:0]}; offset[4:2] picks the 32-bit word.
package dcache_pkg;

  localparam int OFF_W       = 5;
  localparam int WORD_W      = 32;
  localparam int WORD_LSB    = 2;
  localparam int DEF_LINES   = 32;
  localparam int DEF_BLOCK_W = 256;
  localparam int DEF_ADDR_W  = 32;
  localparam int IDX_W       = $clog2(DEF_LINES);
  localparam int TAG_W       = DEF_ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WB_REQ   = 2'd1,
    FILL_REQ = 2'd2,
    REFILL   = 2'd3
  } dc_state_e;

endpackage

// File: rtl/dcache_sram.sv
// dcache_sram: tag/valid/dirty/data storage for the direct-mapped cache.
// Combinational read; synchronous write of a full line (refill) or one word (store hit).
// Valid and dirty clear asynchronously; tag and data are never reset.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int IW    = IDX_W,
  parameter int TW    = TAG_W,
  parameter int BW    = DEF_BLOCK_W
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [IW-1:0]                   rd_idx_i,
  output logic                            rd_valid_o,
  output logic                            rd_dirty_o,
  output logic [TW-1:0]                   rd_tag_o,
  output logic [BW-1:0]                   rd_line_o,
  input  logic [IW-1:0]                   wr_idx_i,
  input  logic                            line_we_i,
  input  logic [TW-1:0]                   wr_tag_i,
  input  logic [BW-1:0]                   wr_line_i,
  input  logic                            word_we_i,
  input  logic [$clog2(BW/WORD_W)-1:0]    wr_wsel_i,
  input  logic [WORD_W-1:0]               wr_word_i
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [BW-1:0]    data_q [LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  // Line state: a refill leaves the line clean, a store marks it dirty
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays: full-line refill or single-word store merge
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end else if (word_we_i) begin
      data_q[wr_idx_i][wr_wsel_i*WORD_W +: WORD_W] <= wr_word_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate L1 D-cache controller (MEM stage).
// Hits complete combinationally; misses walk IDLE -> [WB_REQ] -> FILL_REQ -> REFILL -> IDLE.
// Optional: define DCACHE_STATS_EN to build saturating hit/miss counters; otherwise they read 0.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES   = DEF_LINES,
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               p1_req_i,
  input  logic               p1_write_i,
  input  logic [ADDR_W-1:0]  p1_addr_i,
  input  logic [WORD_W-1:0]  p1_data_i,
  output logic [WORD_W-1:0]  p1_data_o,
  output logic               p1_stall_o,
  output logic               mem_enable_o,
  output logic               mem_write_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [BLOCK_W-1:0] mem_data_o,
  input  logic [BLOCK_W-1:0] mem_data_i,
  input  logic               mem_ack_i,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o
);

  localparam int IW     = $clog2(LINES);
  localparam int TW     = ADDR_W - IW - OFF_W;
  localparam int WSEL_W = $clog2(BLOCK_W / WORD_W);

  dc_state_e state_q, state_d;

  logic [ADDR_W-1:0]  lat_addr_q, cur_addr;
  logic [BLOCK_W-1:0] fill_buf_q;
  logic [IW-1:0]      idx;
  logic [TW-1:0]      tag;
  logic [OFF_W-1:0]   off;
  logic [WSEL_W-1:0]  wsel;

  logic               rd_valid, rd_dirty;
  logic [TW-1:0]      rd_tag;
  logic [BLOCK_W-1:0] rd_line;

  logic idle, hit, miss, load_hit, store_hit;
  logic               mem_en_d, mem_wr_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [BLOCK_W-1:0] mem_data_d;

  // Live address while idle; the latched miss address once the FSM has left IDLE
  assign cur_addr = (state_q == IDLE) ? p1_addr_i : lat_addr_q;
  assign idx      = cur_addr[OFF_W +: IW];
  assign tag      = cur_addr[ADDR_W-1 -: TW];
  assign off      = cur_addr[OFF_W-1:0];
  assign wsel     = WSEL_W'(off >> WORD_LSB);

  assign idle       = (state_q == IDLE);
  assign hit        = p1_req_i & rd_valid & (rd_tag == tag);
  assign miss       = idle & p1_req_i & ~hit;
  assign load_hit   = idle & hit & ~p1_write_i;
  assign store_hit  = idle & hit & p1_write_i;
  assign p1_stall_o = p1_req_i & ~(hit & idle);
  assign p1_data_o  = load_hit ? rd_line[wsel*WORD_W +: WORD_W] : '0;

  dcache_sram #(
    .LINES (LINES),
    .IW    (IW),
    .TW    (TW),
    .BW    (BLOCK_W)
  ) u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd_idx_i   (idx),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .wr_idx_i   (idx),
    .line_we_i  (state_q == REFILL),
    .wr_tag_i   (tag),
    .wr_line_i  (fill_buf_q),
    .word_we_i  (store_hit),
    .wr_wsel_i  (wsel),
    .wr_word_i  (p1_data_i)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: dirty victims go out first, then the new block is fetched
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (miss)      state_d = (rd_valid & rd_dirty) ? WB_REQ : FILL_REQ;
      WB_REQ:   if (mem_ack_i) state_d = FILL_REQ;
      FILL_REQ: if (mem_ack_i) state_d = REFILL;
      REFILL:                  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Memory-port next values; address/data load only when a request is launched
  always_comb begin
    mem_en_d   = (state_d == WB_REQ) || (state_d == FILL_REQ);
    mem_wr_d   = (state_d == WB_REQ);
    mem_addr_d = mem_addr_o;
    mem_data_d = mem_data_o;
    if (idle && state_d == WB_REQ) begin
      mem_addr_d = {rd_tag, idx, {OFF_W{1'b0}}};
      mem_data_d = rd_line;
    end else if (state_d == FILL_REQ && state_q != FILL_REQ) begin
      mem_addr_d = {cur_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end
  end

  // Registered memory port, miss-address latch and fill buffer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      lat_addr_q   <= '0;
      fill_buf_q   <= '0;
    end else begin
      mem_enable_o <= mem_en_d;
      mem_write_o  <= mem_wr_d;
      mem_addr_o   <= mem_addr_d;
      mem_data_o   <= mem_data_d;
      if (miss) lat_addr_q <= p1_addr_i;
      if (state_q == FILL_REQ && mem_ack_i) fill_buf_q <= mem_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating hit/miss counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (idle && hit && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss && miss_cnt_q != '1)         miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed scoreboard bench for dcache_ctrl with a behavioural block memory.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         p1_req_i = 1'b0;
  logic         p1_write_i = 1'b0;
  logic [31:0]  p1_addr_i = '0;
  logic [31:0]  p1_data_i = '0;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i = '0;
  logic         mem_ack_i = 1'b0;
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } mreq_t;

  int total = 0;
  int bad   = 0;
  int lat   = 10;
  int cnt   = 0;

  logic [255:0] mem_blk [logic [31:0]];
  mreq_t        req_q [$];
  logic [31:0]  exp_q [$];

  always #5 clk_i = ~clk_i;

  dcache_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .p1_req_i     (p1_req_i),
    .p1_write_i   (p1_write_i),
    .p1_addr_i    (p1_addr_i),
    .p1_data_i    (p1_data_i),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i),
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  // Block memory: acks after 'lat' cycles of mem_enable_o, one-cycle ack pulse
  always @(negedge clk_i) begin
    if (rst_i) begin
      cnt       = 0;
      mem_ack_i = 1'b0;
    end else begin
      if (mem_ack_i) mem_ack_i = 1'b0;
      if (mem_enable_o) begin
        cnt++;
        if (cnt >= lat) begin
          cnt = 0;
          mem_ack_i = 1'b1;
          req_q.push_back('{wr: mem_write_o, addr: mem_addr_o, data: mem_data_o});
          if (mem_write_o) mem_blk[mem_addr_o] = mem_data_o;
          else mem_data_i = mem_blk.exists(mem_addr_o) ? mem_blk[mem_addr_o] : '0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the next logged memory request and compare direction/address
  task automatic chk_req(input bit wr, input logic [31:0] a, input string tag, output logic [255:0] d);
    mreq_t r;
    logic [32:0] obs;
    obs = 'x;
    d   = 'x;
    if (req_q.size() > 0) begin
      r   = req_q.pop_front();
      obs = {r.wr, r.addr};
      d   = r.data;
    end
    chk(tag, 256'(obs), 256'({wr, a}));
  endtask

  // One CPU access: push expected data, wait (bounded) for stall release, compare
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_d, input int exp_stall, input string tag);
    int n;
    @(negedge clk_i);
    p1_req_i = 1'b1; p1_write_i = wr; p1_addr_i = a; p1_data_i = d;
    exp_q.push_back(exp_d);
    #1;
    n = 0;
    while (p1_stall_o && n < 500) begin
      @(negedge clk_i); #1; n++;
    end
    chk({tag, "_stall"}, 256'(n), 256'(exp_stall));
    chk({tag, "_data"}, 256'(p1_data_o), 256'(exp_q.pop_front()));
    @(negedge clk_i);
    p1_req_i = 1'b0; p1_write_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] b, wd;

    b = '0; b[31:0] = 32'hDEADBEEF; b[63:32] = 32'h11111111; b[95:64] = 32'h22222222;
    mem_blk[32'h40] = b;
    b = '0; b[31:0] = 32'hCAFEF00D; b[63:32] = 32'h33333333;
    mem_blk[32'h440] = b;
    b = '0; b[31:0] = 32'h0BADF00D;
    mem_blk[32'h840] = b;

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_mem_en", 256'(mem_enable_o), 256'(0));
    chk("rst_mem_wr", 256'(mem_write_o), 256'(0));
    chk("rst_mem_addr", 256'(mem_addr_o), 256'(0));
    chk("rst_mem_data", mem_data_o, 256'(0));
    chk("rst_noreq_stall", 256'(p1_stall_o), 256'(0));
    chk("rst_data", 256'(p1_data_o), 256'(0));
    p1_req_i = 1'b1; p1_addr_i = 32'h40;
    #1;
    chk("rst_cold_stall", 256'(p1_stall_o), 256'(1));
    p1_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;

    // Cold load miss, ack after 10 cycles
    lat = 10;
    access(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 12, "cold_ld");
    chk_req(1'b0, 32'h40, "cold_fill", wd);
    chk("idle_en", 256'(mem_enable_o), 256'(0));

    // Store hit, then read back
    lat = 3;
    access(1'b1, 32'h44, 32'h12345678, 32'h0, 0, "st_hit");
    access(1'b0, 32'h44, 32'h0, 32'h12345678, 0, "ld_44");
    access(1'b0, 32'h48, 32'h0, 32'h22222222, 0, "ld_48");
    chk("no_mem_on_hit", 256'(req_q.size()), 256'(0));

    // Dirty conflict miss: write-back then fill
    access(1'b0, 32'h440, 32'h0, 32'hCAFEF00D, 8, "dirty_ld");
    chk_req(1'b1, 32'h40, "wb_req", wd);
    chk("wb_word1", 256'(wd[63:32]), 256'(32'h12345678));
    chk("wb_word0", 256'(wd[31:0]), 256'(32'hDEADBEEF));
    chk_req(1'b0, 32'h440, "fill_440", wd);

    // Clean conflict miss: fill only, sees the written-back store
    access(1'b0, 32'h44, 32'h0, 32'h12345678, 5, "clean_ld");
    chk_req(1'b0, 32'h40, "clean_fill", wd);
    chk("clean_no_wb", 256'(req_q.size()), 256'(0));

    // Reset asserted mid-fill
    lat = 10;
    @(negedge clk_i);
    p1_req_i = 1'b1; p1_addr_i = 32'h840;
    repeat (4) @(negedge clk_i);
    #1;
    chk("fill_en", 256'(mem_enable_o), 256'(1));
    #1;
    rst_i = 1'b1;
    #1;
    chk("rst_async_en", 256'(mem_enable_o), 256'(0));
    chk("rst_stall", 256'(p1_stall_o), 256'(1));
    p1_req_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_hit_cnt", 256'(hit_cnt_o), 256'(0));
    chk("rst_miss_cnt", 256'(miss_cnt_o), 256'(0));

    // Re-access misses again; then 1 hit, then one more clean miss
    lat = 3;
    access(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 5, "re_miss");
    chk_req(1'b0, 32'h40, "re_fill", wd);
    access(1'b0, 32'h44, 32'h0, 32'h12345678, 0, "re_hit");
    access(1'b0, 32'h840, 32'h0, 32'h0BADF00D, 5, "ld_840");
    chk_req(1'b0, 32'h840, "fill_840", wd);
    chk("end_req_q", 256'(req_q.size()), 256'(0));

`ifdef DCACHE_STATS_EN
    chk("hit_cnt", 256'(hit_cnt_o), 256'(3));
    chk("miss_cnt", 256'(miss_cnt_o), 256'(2));
`else
    chk("hit_cnt", 256'(hit_cnt_o), 256'(0));
    chk("miss_cnt", 256'(miss_cnt_o), 256'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller in the MEM stage.
- Sits between the EX/MEM pipeline register and the MEM/WB register.
- Supplies load data to MEM/WB and drives the pipeline-wide memory stall.
- Talks to off-chip data memory over a 256-bit block req/ack interface.

Parameters:
- LINES, 32, number of cache lines; power of two; index width = log2(LINES).
- BLOCK_W, 256, line size in bits (32 bytes); offset width = 5.
- ADDR_W, 32, byte address width; tag width = ADDR_W - index - offset.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- p1_req_i  in  1  CPU access valid (MemRead | MemWrite)
- p1_write_i  in  1  1 = store, 0 = load
- p1_addr_i  in  32  byte address; word-aligned, bits [1:0] ignored
- p1_data_i  in  32  store data
- p1_data_o  out  32  load data, combinational on hit
- p1_stall_o  out  1  pipeline stall; feeds stall_i of all pipeline registers
- mem_enable_o  out  1  memory request valid
- mem_write_o  out  1  1 = block write-back, 0 = block fill
- mem_addr_o  out  32  block-aligned address, bits [4:0] = 0
- mem_data_o  out  256  write-back block
- mem_data_i  in  256  fill block, valid when mem_ack_i = 1
- mem_ack_i  in  1  one-cycle completion pulse from memory

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-high on rst_i.
- Reset values:
  - state = IDLE; all valid and dirty bits = 0.
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
  - p1_stall_o follows the hit logic; with valid = 0, any request stalls.
  - Tag and data arrays are not reset.
- Hit (combinational):
  - hit = p1_req_i & valid[idx] & (tag[idx] == addr tag).
  - p1_stall_o = p1_req_i & ~(hit & state == IDLE).
  - No request means no stall.
- Load hit:
  - p1_data_o = word at offset[4:2] of the line, same cycle, zero extra latency.
  - When not a load hit, p1_data_o = 0.
- Store hit:
  - At the posedge, write the 32-bit word into the line and set dirty[idx] = 1.
  - No stall.
- FSM states: IDLE, WB_REQ, FILL_REQ, REFILL.
  - IDLE: on a miss (p1_req_i & ~hit), go to WB_REQ if valid & dirty, else FILL_REQ.
  - WB_REQ: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {old tag, idx, 5'b0}, mem_data_o = old line. On mem_ack_i go to FILL_REQ.
  - FILL_REQ: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {new tag, idx, 5'b0}. On mem_ack_i, capture mem_data_i into the fill buffer and go to REFILL.
  - REFILL: write the fill buffer into the line; valid = 1, dirty = 0, tag = new tag. Go to IDLE; the next cycle re-evaluates and hits.
- Miss latency: ack latency, plus 1 cycle (REFILL), plus 1 cycle (hit in IDLE). A write-back adds its own ack latency.
- mem_enable_o is registered and held high until the cycle after mem_ack_i. Memory must not see a new request before the ack.
- mem_ack_i in IDLE or REFILL is ignored.
- p1_addr_i / p1_write_i / p1_data_i are held stable by the stalled pipeline. The controller latches the miss address on leaving IDLE and uses the latched copy thereafter.
- Reset mid-miss: the FSM returns to IDLE immediately and mem_enable_o drops. An in-flight memory transaction is abandoned; memory must also be reset.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined, two 32-bit saturating counters are built:
  - hit_cnt_o: increments on each IDLE cycle with p1_req_i & hit.
  - miss_cnt_o: increments on each IDLE-to-miss transition.
  - Both reset to 0.
- When undefined, hit_cnt_o and miss_cnt_o still exist and are tied to 0; no counter flops are built.

Decomposition:
- Package dcache_pkg:
  - State encoding (IDLE = 2'd0, WB_REQ = 2'd1, FILL_REQ = 2'd2, REFILL = 2'd3).
  - OFF_W = 5, IDX_W, TAG_W, BLOCK_W.
  - Address-slice helper constants.
- One sub-module, dcache_sram:
  - Tag, valid, dirty and data arrays.
  - Combinational read port; synchronous write port with full-line or single-word enable.
  - Asynchronous clear of valid and dirty.

Test Plan:
- Cold load 0x0000_0040, memory returns a block with word0 = 0xDEADBEEF, ack after 10 cycles -> stall high for 12 cycles; mem_addr_o = 0x40, mem_write_o = 0; then p1_data_o = 0xDEADBEEF with stall low.
- Store 0x12345678 to 0x44 after the fill -> no stall; a following load of 0x44 returns 0x12345678; dirty[2] = 1.
- Load 0x0000_0440 (same index 2, new tag) -> WB_REQ first with mem_addr_o = 0x40, mem_data_o word1 = 0x12345678; then FILL_REQ with mem_addr_o = 0x440.
- Clean conflict miss -> no WB_REQ; FILL_REQ directly.
- Assert rst_i during FILL_REQ -> mem_enable_o = 0 asynchronously; a re-access to the same address misses again.
- With DCACHE_STATS_EN, run 3 hits and 2 misses -> hit_cnt_o = 3, miss_cnt_o = 2. Without the macro -> both read 0.
